sa_top_ram_core: RTL and testbench

//  AXI-Lite-controlled matrix-multiply engine with RAM-style memory ports.

---
 rtl/sa_top_ram_core.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_sa_top_ram_core.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_top_ram_core.sv
// sa_top_ram_core: AXI-Lite controlled matrix-multiply engine with RAM-style memory ports.
//   Y[r][c] = A[r][c] + sum_k K[k][r] * X[k][c] over an R x C output tile.
//   Optional feature macro SA_TOP_RAM_BIAS_EN: when defined, A is fetched on mm2s_2 and
//   seeds the accumulator; otherwise mm2s_2 is idle and the accumulator starts at zero.
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   s_axil_*            AXI4-Lite slave: 8 x 32-bit registers at AXIL_BASE_ADDR
//   mm2s_0/1/2_*        read ports for K / X / A (word address, data returns one cycle later)
//   s2mm_*              write port for Y (one wen pulse per output element)
// Registers: 0 CTRL/STATUS (bit0 START w1, bit1 BUSY ro, bit2 DONE sticky), 1 K base,
//   2 X base, 3 A base, 4 Y base, 5 KD depth, 6..7 scratch.
module sa_top_ram_core #(
  parameter int unsigned R               = 4,
  parameter int unsigned C               = 4,
  parameter int unsigned WK              = 8,
  parameter int unsigned WX              = 8,
  parameter int unsigned WA              = 32,
  parameter int unsigned WY              = 32,
  parameter int unsigned AXI_WIDTH       = 32,
  parameter int unsigned AXI_ADDR_WIDTH  = 32,
  parameter int unsigned AXIL_WIDTH      = 32,
  parameter int unsigned AXIL_ADDR_WIDTH = 32,
  parameter int unsigned STRB_WIDTH      = 4,
  parameter logic [AXIL_ADDR_WIDTH-1:0] AXIL_BASE_ADDR = 32'hA000_0000,
  localparam int unsigned LSB = $clog2(AXI_WIDTH) - 3,
  localparam int unsigned MAW = AXI_ADDR_WIDTH - LSB
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]                 s_axil_awprot,
  input  logic                       s_axil_awvalid,
  output logic                       s_axil_awready,
  input  logic [AXIL_WIDTH-1:0]      s_axil_wdata,
  input  logic [STRB_WIDTH-1:0]      s_axil_wstrb,
  input  logic                       s_axil_wvalid,
  output logic                       s_axil_wready,
  output logic [1:0]                 s_axil_bresp,
  output logic                       s_axil_bvalid,
  input  logic                       s_axil_bready,
  input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]                 s_axil_arprot,
  input  logic                       s_axil_arvalid,
  output logic                       s_axil_arready,
  output logic [AXIL_WIDTH-1:0]      s_axil_rdata,
  output logic [1:0]                 s_axil_rresp,
  output logic                       s_axil_rvalid,
  input  logic                       s_axil_rready,
  output logic                       mm2s_0_ren,
  output logic [MAW-1:0]             mm2s_0_addr,
  input  logic [AXI_WIDTH-1:0]       mm2s_0_data,
  output logic                       mm2s_1_ren,
  output logic [MAW-1:0]             mm2s_1_addr,
  input  logic [AXI_WIDTH-1:0]       mm2s_1_data,
  output logic                       mm2s_2_ren,
  output logic [MAW-1:0]             mm2s_2_addr,
  input  logic [AXI_WIDTH-1:0]       mm2s_2_data,
  output logic                       s2mm_wen,
  output logic [MAW-1:0]             s2mm_addr,
  output logic [AXI_WIDTH-1:0]       s2mm_data,
  output logic [AXI_WIDTH/8-1:0]     s2mm_strb
);

  localparam int unsigned NREG = 8;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic [2:0] {StIdle, StLoadA, StMac, StDrain, StWrite} state_e;

  // ---------------------------------------------------------------- AXI-Lite
  logic                       awready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]                 bresp_q, rresp_q;
  logic [AXIL_WIDTH-1:0]      rdata_q, rd_val, status;
  logic [AXIL_WIDTH-1:0]      cfg_q [NREG];
  logic [AXIL_ADDR_WIDTH-1:0] wr_off, rd_off;
  logic                       wr_in_range, rd_in_range, wr_commit, rd_commit;
  logic [2:0]                 wr_idx, rd_idx;

  // Subtraction wraps addresses below the base to huge offsets, so one range test suffices.
  assign wr_off      = s_axil_awaddr - AXIL_BASE_ADDR;
  assign rd_off      = s_axil_araddr - AXIL_BASE_ADDR;
  assign wr_in_range = (wr_off[AXIL_ADDR_WIDTH-1:5] == '0);
  assign rd_in_range = (rd_off[AXIL_ADDR_WIDTH-1:5] == '0);
  assign wr_idx      = wr_off[4:2];
  assign rd_idx      = rd_off[4:2];
  assign wr_commit   = awready_q & s_axil_awvalid & s_axil_wvalid;
  assign rd_commit   = arready_q & s_axil_arvalid;

  assign s_axil_awready = awready_q;
  assign s_axil_wready  = awready_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = arready_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;

  // ---------------------------------------------------------------- engine state
  state_e               state_q, state_d, first_st;
  logic [31:0]          r_q, r_d, c_q, c_d, k_q, k_d, kd_q, elem;
  logic [WA-1:0]        acc_q, acc_d;
  logic                 done_q, done_d, p_pend_q, busy, start, last_elem;
  logic                 ren01, ren2, wen;
  logic [MAW-1:0]       kb_q, xb_q, yb_q;

  assign busy   = (state_q != StIdle);
  assign status = AXIL_WIDTH'({done_q, busy, 1'b0});
  assign start  = wr_commit & wr_in_range & (wr_idx == 3'd0) & s_axil_wstrb[0] &
                  s_axil_wdata[0] & ~busy;

  always_comb begin
    rd_val = '0;
    if (rd_in_range) begin
      if (rd_idx == 3'd0) rd_val = status;
      else                rd_val = cfg_q[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RespOkay;
      rdata_q   <= '0;
      for (int i = 0; i < NREG; i++) cfg_q[i] <= '0;
    end else begin
      awready_q <= s_axil_awvalid & s_axil_wvalid & ~awready_q & ~bvalid_q;
      if (wr_commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_in_range ? RespOkay : RespSlverr;
      end else if (s_axil_bready) begin
        bvalid_q <= 1'b0;
      end
      // cfg[0] has no storage of its own: START is a pulse and DONE lives in done_q.
      for (int i = 1; i < NREG; i++) begin
        if (wr_commit && wr_in_range && wr_idx == 3'(i)) begin
          for (int b = 0; b < STRB_WIDTH; b++) begin
            if (s_axil_wstrb[b]) cfg_q[i][8*b +: 8] <= s_axil_wdata[8*b +: 8];
          end
        end
      end
      arready_q <= s_axil_arvalid & ~arready_q & ~rvalid_q;
      if (rd_commit) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_val;
        rresp_q  <= rd_in_range ? RespOkay : RespSlverr;
      end else if (s_axil_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- datapath
  logic signed [WK-1:0]    k_el;
  logic signed [WX-1:0]    x_el;
  logic signed [WK+WX-1:0] prod;
  logic signed [WA-1:0]    prod_ext;
  logic signed [WY-1:0]    y_s;

  assign k_el     = mm2s_0_data[WK-1:0];
  assign x_el     = mm2s_1_data[WX-1:0];
  assign prod     = k_el * x_el;
  assign prod_ext = WA'(prod);
  assign y_s      = acc_q[WY-1:0];
  assign elem     = r_q * C + c_q;
  assign last_elem = (r_q == R - 1) && (c_q == C - 1);

`ifdef SA_TOP_RAM_BIAS_EN
  logic                 a_pend_q;
  logic [MAW-1:0]       ab_q;
  logic signed [WA-1:0] a_ext;
  assign a_ext = WA'($signed(mm2s_2_data));
  always_comb first_st = StLoadA;
`else
  // Without bias a zero-depth run has nothing to read, so go straight to DRAIN.
  always_comb begin
    if (state_q == StIdle) first_st = (cfg_q[5] == '0) ? StDrain : StMac;
    else                   first_st = (kd_q == '0) ? StDrain : StMac;
  end
`endif

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    k_d     = k_q;
    acc_d   = acc_q;
    done_d  = done_q;
    ren01   = 1'b0;
    ren2    = 1'b0;
    wen     = 1'b0;
    // Read data lands one cycle after its enable; fold it in on that cycle.
`ifdef SA_TOP_RAM_BIAS_EN
    if (a_pend_q)      acc_d = a_ext;
    else if (p_pend_q) acc_d = acc_q + prod_ext;
`else
    if (p_pend_q)      acc_d = acc_q + prod_ext;
`endif
    unique case (state_q)
      StIdle: begin
        acc_d = '0;
        if (start) begin
          done_d  = 1'b0;
          r_d     = '0;
          c_d     = '0;
          k_d     = '0;
          state_d = first_st;
        end
      end
      StLoadA: begin
        ren2    = 1'b1;
        state_d = (kd_q == '0) ? StDrain : StMac;
      end
      StMac: begin
        ren01 = 1'b1;
        if (k_q == kd_q - 1) state_d = StDrain;
        else                 k_d = k_q + 1;
      end
      StDrain: state_d = StWrite;
      StWrite: begin
        wen   = 1'b1;
        acc_d = '0;
        k_d   = '0;
        if (last_elem) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          if (c_q == C - 1) begin
            c_d = '0;
            r_d = r_q + 1;
          end else begin
            c_d = c_q + 1;
          end
          state_d = first_st;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      r_q      <= '0;
      c_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      done_q   <= 1'b0;
      p_pend_q <= 1'b0;
      kd_q     <= '0;
      kb_q     <= '0;
      xb_q     <= '0;
      yb_q     <= '0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      c_q      <= c_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      done_q   <= done_d;
      p_pend_q <= (state_q == StMac);
      // Snapshot the run configuration so firmware writes during a run affect only the next.
      if (start) begin
        kb_q <= cfg_q[1][AXI_ADDR_WIDTH-1:LSB];
        xb_q <= cfg_q[2][AXI_ADDR_WIDTH-1:LSB];
        yb_q <= cfg_q[4][AXI_ADDR_WIDTH-1:LSB];
        kd_q <= cfg_q[5];
      end
    end
  end

`ifdef SA_TOP_RAM_BIAS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      a_pend_q <= 1'b0;
      ab_q     <= '0;
    end else begin
      a_pend_q <= (state_q == StLoadA);
      if (start) ab_q <= cfg_q[3][AXI_ADDR_WIDTH-1:LSB];
    end
  end
  assign mm2s_2_ren  = ren2;
  assign mm2s_2_addr = ren2 ? ab_q + MAW'(elem) : '0;
`else
  assign mm2s_2_ren  = 1'b0;
  assign mm2s_2_addr = '0;
`endif

  assign mm2s_0_ren  = ren01;
  assign mm2s_1_ren  = ren01;
  assign mm2s_0_addr = ren01 ? kb_q + MAW'(k_q * R + r_q) : '0;
  assign mm2s_1_addr = ren01 ? xb_q + MAW'(k_q * C + c_q) : '0;
  assign s2mm_wen    = wen;
  assign s2mm_addr   = wen ? yb_q + MAW'(elem) : '0;
  assign s2mm_data   = wen ? AXI_WIDTH'(y_s) : '0;
  assign s2mm_strb   = '1;

  // Bits that are intentionally ignored (prot, high data bits, low address bits).
  logic unused_ok;
  assign unused_ok = ^{s_axil_awprot, s_axil_arprot, mm2s_0_data, mm2s_1_data, mm2s_2_data,
                       wr_off[1:0], rd_off[1:0], cfg_q[1], cfg_q[2], cfg_q[3], cfg_q[4],
                       acc_q, ren2};

endmodule

// File: tb/tb_sa_top_ram_core.sv
module tb_sa_top_ram_core;

  localparam logic [31:0] BASE = 32'hA000_0000;
`ifdef SA_TOP_RAM_BIAS_EN
  localparam bit BIAS = 1'b1;
`else
  localparam bit BIAS = 1'b0;
`endif

  logic        clk, rst;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [3:0]  wstrb, s2mm_strb;
  logic [1:0]  bresp, rresp;
  logic        ren0, ren1, ren2, wen;
  logic [29:0] addr0, addr1, addr2, waddr;
  logic [31:0] data0, data1, data2, wdat;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem  [512];
  logic [31:0] ymem [512];
  int ren0_cnt = 0, ren1_cnt = 0, ren2_cnt = 0, wen_cnt = 0, strb_bad = 0;

  sa_top_ram_core #(.R(2), .C(2)) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid),
    .s_axil_awready(awready), .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
    .s_axil_wvalid(wvalid), .s_axil_wready(wready), .s_axil_bresp(bresp),
    .s_axil_bvalid(bvalid), .s_axil_bready(bready), .s_axil_araddr(araddr),
    .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid),
    .s_axil_rready(rready),
    .mm2s_0_ren(ren0), .mm2s_0_addr(addr0), .mm2s_0_data(data0),
    .mm2s_1_ren(ren1), .mm2s_1_addr(addr1), .mm2s_1_data(data1),
    .mm2s_2_ren(ren2), .mm2s_2_addr(addr2), .mm2s_2_data(data2),
    .s2mm_wen(wen), .s2mm_addr(waddr), .s2mm_data(wdat), .s2mm_strb(s2mm_strb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: read data one cycle after ren; record every write.
  always @(posedge clk) begin
    if (ren0) begin data0 <= mem[addr0[8:0]]; ren0_cnt <= ren0_cnt + 1; end
    if (ren1) begin data1 <= mem[addr1[8:0]]; ren1_cnt <= ren1_cnt + 1; end
    if (ren2) begin data2 <= mem[addr2[8:0]]; ren2_cnt <= ren2_cnt + 1; end
    if (wen) begin
      ymem[waddr[8:0]] <= wdat;
      wen_cnt <= wen_cnt + 1;
      if (s2mm_strb !== 4'hF) strb_bad <= strb_bad + 1;
    end
  end

  task automatic axil_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
    int n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!awready && n < 20);
    if (!awready) begin
      checks++; errors++;
      $display("FAIL axil_write_ready addr=%h got awready=%b want 1", a, awready);
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bvalid && n < 20);
    if (!bvalid) begin
      checks++; errors++;
      $display("FAIL axil_write_bvalid addr=%h got bvalid=%b want 1", a, bvalid);
    end
    resp = bresp;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axil_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    araddr = a; arvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!arready && n < 20);
    if (!arready) begin
      checks++; errors++;
      $display("FAIL axil_read_ready addr=%h got arready=%b want 1", a, arready);
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rvalid && n < 20);
    if (!rvalid) begin
      checks++; errors++;
      $display("FAIL axil_read_rvalid addr=%h got rvalid=%b want 1", a, rvalid);
    end
    d = rdata; resp = rresp;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic program_run(input logic [31:0] yb, input logic [31:0] kd);
    logic [1:0] r;
    axil_write(BASE + 32'h04, 32'h100, 4'hF, r);
    axil_write(BASE + 32'h08, 32'h200, 4'hF, r);
    axil_write(BASE + 32'h0C, 32'h300, 4'hF, r);
    axil_write(BASE + 32'h10, yb, 4'hF, r);
    axil_write(BASE + 32'h14, kd, 4'hF, r);
  endtask

  task automatic start_run();
    logic [1:0] r;
    axil_write(BASE, 32'h1, 4'hF, r);
  endtask

  // Poll STATUS until DONE or the budget runs out; returns the last status word.
  task automatic wait_done(output logic [31:0] st);
    logic [1:0] r;
    int n = 0;
    do begin axil_read(BASE, st, r); n++; end while (st[2] !== 1'b1 && n < 200);
  endtask

  // K words 64.., X words 128.., A words 192..
  task automatic load_matmul();
    mem[64] = 1;  mem[65] = 2;  mem[66] = 3;  mem[67] = 4;
    mem[128] = 5; mem[129] = 6; mem[130] = 7; mem[131] = 8;
    for (int i = 0; i < 4; i++) mem[192 + i] = 0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ren0, ren1, ren2, wen} !== 4'b0) begin
      errors++; $display("FAIL reset_ren_wen got %b want 0000", {ren0, ren1, ren2, wen});
    end
    checks++;
    if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_axil_handshake got %b want 00000",
               {awready, wready, bvalid, arready, rvalid});
    end
    checks++;
    if ({addr0, addr1, addr2, waddr, wdat, rdata, bresp, rresp} !== '0) begin
      errors++; $display("FAIL reset_addr_data got nonzero want all zero");
    end
    rst = 1'b0;
    @(posedge clk); #1;
    axil_read(BASE, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b00) begin
      errors++; $display("FAIL reset_status got data=%h resp=%b want 0 00", d, r);
    end
  endtask

  task automatic test_axil();
    logic [31:0] d;
    logic [1:0]  r;
    axil_write(BASE + 32'h18, 32'h1234, 4'hF, r);
    checks++;
    if (r !== 2'b00) begin errors++; $display("FAIL scratch_bresp got %b want 00", r); end
    axil_read(BASE + 32'h18, d, r);
    checks++;
    if (d !== 32'h1234 || r !== 2'b00) begin
      errors++; $display("FAIL scratch_readback got %h/%b want 00001234/00", d, r);
    end
    axil_write(BASE + 32'h1C, 32'hFFFF_FFFF, 4'b0001, r);
    axil_read(BASE + 32'h1C, d, r);
    checks++;
    if (d !== 32'h0000_00FF) begin
      errors++; $display("FAIL wstrb_byte0 got %h want 000000ff", d);
    end
    axil_write(BASE + 32'h1C, 32'hAABB_CCDD, 4'b1010, r);
    axil_read(BASE + 32'h1C, d, r);
    checks++;
    if (d !== 32'hAA00_CCFF) begin
      errors++; $display("FAIL wstrb_bytes13 got %h want aa00ccff", d);
    end
    axil_read(BASE + 32'h40, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b10) begin
      errors++; $display("FAIL oor_read got %h/%b want 00000000/10", d, r);
    end
    axil_write(BASE + 32'h40, 32'h5, 4'hF, r);
    checks++;
    if (r !== 2'b10) begin errors++; $display("FAIL oor_write_bresp got %b want 10", r); end
  endtask

  task automatic test_matmul();
    logic [31:0] st;
    logic [31:0] exp_y [4];
    int w0, k0, a0;
    exp_y[0] = 26; exp_y[1] = 30; exp_y[2] = 38; exp_y[3] = 44;
    load_matmul();
    program_run(32'h400, 2);
    w0 = wen_cnt; k0 = ren0_cnt; a0 = ren2_cnt;
    start_run();
    wait_done(st);
    checks++;
    if (st !== 32'h4) begin errors++; $display("FAIL matmul_status got %h want 00000004", st); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ymem[256 + i] !== exp_y[i]) begin
        errors++; $display("FAIL matmul_y%0d got %0d want %0d", i, ymem[256 + i], exp_y[i]);
      end
    end
    checks++;
    if (wen_cnt - w0 !== 4) begin
      errors++; $display("FAIL matmul_wen_count got %0d want 4", wen_cnt - w0);
    end
    checks++;
    if (ren0_cnt - k0 !== 8) begin
      errors++; $display("FAIL matmul_ren0_count got %0d want 8", ren0_cnt - k0);
    end
    checks++;
    if (ren2_cnt - a0 !== (BIAS ? 4 : 0)) begin
      errors++; $display("FAIL matmul_ren2_count got %0d want %0d", ren2_cnt - a0, BIAS ? 4 : 0);
    end
    checks++;
    if (strb_bad !== 0) begin errors++; $display("FAIL s2mm_strb got %0d bad want 0", strb_bad); end
  endtask

  task automatic test_signed();
    logic [31:0] st, exp;
    mem[64] = 32'hFFFF_FFFD; mem[65] = 32'hFFFF_FFFD;
    mem[128] = 5; mem[129] = 5;
    for (int i = 0; i < 4; i++) mem[192 + i] = 100;
    exp = BIAS ? 32'h0000_0055 : 32'hFFFF_FFF1;
    program_run(32'h480, 1);
    start_run();
    wait_done(st);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ymem[288 + i] !== exp) begin
        errors++; $display("FAIL signed_y%0d got %h want %h", i, ymem[288 + i], exp);
      end
    end
  endtask

  task automatic test_kd0();
    logic [31:0] st;
    logic [31:0] a [4];
    int k0, x0, w0;
    a[0] = 7; a[1] = 32'hFFFF_FFFE; a[2] = 300; a[3] = 32'h1234_5678;
    for (int i = 0; i < 4; i++) mem[192 + i] = a[i];
    program_run(32'h500, 0);
    k0 = ren0_cnt; x0 = ren1_cnt; w0 = wen_cnt;
    start_run();
    wait_done(st);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ymem[320 + i] !== (BIAS ? a[i] : 32'h0)) begin
        errors++;
        $display("FAIL kd0_y%0d got %h want %h", i, ymem[320 + i], BIAS ? a[i] : 32'h0);
      end
    end
    checks++;
    if (ren0_cnt != k0 || ren1_cnt != x0) begin
      errors++; $display("FAIL kd0_no_kx_reads got %0d/%0d want 0/0", ren0_cnt - k0, ren1_cnt - x0);
    end
    checks++;
    if (wen_cnt - w0 !== 4) begin
      errors++; $display("FAIL kd0_wen_count got %0d want 4", wen_cnt - w0);
    end
  endtask

  task automatic test_start_busy();
    logic [31:0] st;
    logic [1:0]  r;
    int w0;
    load_matmul();
    program_run(32'h580, 2);
    w0 = wen_cnt;
    start_run();
    axil_read(BASE, st, r);
    checks++;
    if (st !== 32'h2) begin errors++; $display("FAIL busy_status got %h want 00000002", st); end
    start_run();
    wait_done(st);
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (wen_cnt - w0 !== 4) begin
      errors++; $display("FAIL start_busy_wen_count got %0d want 4", wen_cnt - w0);
    end
    checks++;
    if (ymem[352] !== 26 || ymem[355] !== 44) begin
      errors++; $display("FAIL start_busy_y got %0d,%0d want 26,44", ymem[352], ymem[355]);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] st;
    logic [1:0]  r;
    int n = 0;
    int w0;
    load_matmul();
    program_run(32'h600, 2);
    w0 = wen_cnt;
    start_run();
    do begin @(negedge clk); n++; end while (!ren0 && n < 50);
    checks++;
    if (ren0 !== 1'b1) begin errors++; $display("FAIL mid_reach_mac got ren0=%b want 1", ren0); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({ren0, ren1, ren2, wen} !== 4'b0) begin
      errors++; $display("FAIL mid_reset_ren_wen got %b want 0000", {ren0, ren1, ren2, wen});
    end
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    axil_read(BASE, st, r);
    checks++;
    if (st !== 32'h0 || wen_cnt != w0) begin
      errors++; $display("FAIL mid_reset_idle got status=%h wen=%0d want 0 0", st, wen_cnt - w0);
    end
    program_run(32'h680, 2);
    start_run();
    wait_done(st);
    checks++;
    if (ymem[416] !== 26 || ymem[417] !== 30 || ymem[418] !== 38 || ymem[419] !== 44) begin
      errors++;
      $display("FAIL restart_y got %0d,%0d,%0d,%0d want 26,30,38,44",
               ymem[416], ymem[417], ymem[418], ymem[419]);
    end
  endtask

  initial begin
    rst = 1'b1;
    awaddr = '0; wdata = '0; wstrb = '0; awprot = '0; araddr = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < 512; i++) mem[i] = '0;
    test_reset();
    test_axil();
    test_matmul();
    test_signed();
    test_kd0();
    test_start_busy();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
